// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous memory port between the CPU path (m0) and
// the loader/debug path (m1): fixed priority to m0 with bounded starvation of m1.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    IDLE  = 1'b0,
    RDATA = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               m0_win, m1_win;

  // Byte offset within a word never reaches the memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Winner selection, grant/memory drive and read-data return.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    m0_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_gnt    = 1'b0;
    m1_rvalid = 1'b0;
    m1_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;

    m1_win = m1_req && (!m0_req || (starve_q == LIMIT));
    m0_win = m0_req && !m1_win;

    // Outputs are held at zero for as long as reset is asserted.
    if (!reset_n) begin
      state_d = IDLE;
    end else if (state_q == RDATA) begin
      if (owner_q) begin
        m1_rvalid = 1'b1;
        m1_rdata  = mem_rdata;
      end else begin
        m0_rvalid = 1'b1;
        m0_rdata  = mem_rdata;
      end
      state_d = IDLE;
    end else begin
      if (m1_win) begin
        m1_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_we    = m1_we ? m1_wstrb : 4'b0000;
        mem_addr  = m1_addr[ADDR_WIDTH-1:2];
        mem_wdata = m1_wdata;
        if (!m1_we) begin
          state_d = RDATA;
          owner_d = 1'b1;
        end
      end else if (m0_win) begin
        m0_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_we    = m0_we ? m0_wstrb : 4'b0000;
        mem_addr  = m0_addr[ADDR_WIDTH-1:2];
        mem_wdata = m0_wdata;
        if (!m0_we) begin
          state_d = RDATA;
          owner_d = 1'b0;
        end
      end

      if (m0_win && m1_req) begin
        starve_d = (starve_q == LIMIT) ? starve_q : CNT_W'(starve_q + 4'd1);
      end else begin
        starve_d = '0;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous unified memory port between two requesters: m0 is the multicycle CPU's fetch/load/store path and m1 is the program-loader/debug port.
- Sequences each access through a small FSM, which absorbs the 1-cycle memory read latency.
- Arbitration is fixed-priority to m0, with a bounded-starvation override for m1.
- Sits between the CPU memory interface (InstructionOrData mux output) and the RAM.

Parameters:
ADDR_WIDTH, 32, byte-address width of requester ports
DATA_WIDTH, 32, data width; must be 32 (4 byte lanes)
STARVE_LIMIT, 4, max consecutive m0 grants while m1 is requesting; range 1..15

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
m0_req  in  1  m0 access request; held with command until m0_gnt
m0_we  in  1  1=write, 0=read
m0_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
m0_wdata  in  DATA_WIDTH  write data
m0_wstrb  in  4  byte-lane write enables
m0_gnt  out  1  command accepted this cycle
m0_rvalid  out  1  read data valid this cycle
m0_rdata  out  DATA_WIDTH  read data; 0 when m0_rvalid=0
m1_*  same set as m0_*, for requester m1
mem_en  out  1  memory access strobe
mem_we  out  4  per-lane write enable; 0 for reads
mem_addr  out  ADDR_WIDTH-2  word address = granted addr[ADDR_WIDTH-1:2]
mem_wdata  out  DATA_WIDTH  granted write data
mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after a read strobe

Behaviour:
- FSM states: IDLE and RDATA. Registers: state, owner (0/1), starve_cnt (4 bits).
- Reset (reset_n=0, async):
  - state=IDLE, owner=0, starve_cnt=0.
  - All outputs 0: gnt, rvalid, rdata, mem_en, mem_we.
- IDLE winner selection:
  - m1 wins if m1_req=1 and (m0_req=0 or starve_cnt==STARVE_LIMIT).
  - Otherwise m0 wins if m0_req=1.
  - Otherwise no grant and all memory outputs are 0.
- Grant cycle, combinational, same cycle as the request is seen:
  - gnt of the winner =1.
  - mem_en=1; mem_addr and mem_wdata come from the winner.
  - Write: mem_we=winner wstrb.
  - Read: mem_we=0.
- Write:
  - Completes in the grant cycle; state stays IDLE.
  - Back-to-back writes are possible every cycle.
  - wstrb=0 still asserts mem_en and gnt; no bytes change.
- Read:
  - On the grant, owner<=winner and state<=RDATA.
  - In RDATA: owner's rvalid=1 and owner's rdata=mem_rdata.
  - No grant is issued in RDATA, so read throughput is 1 per 2 cycles. Next state is IDLE.
- starve_cnt update, on each grant cycle:
  - m0 granted while m1_req=1: increment, saturating at STARVE_LIMIT.
  - m1 granted, or m1_req=0: clear to 0.
  - Unchanged in RDATA.
- The non-winning requester keeps req asserted and sees gnt=0. Commands must not change until granted; the arbiter does not latch them.
- Dropping req before gnt is legal: the request is discarded and no access is made.
- Only one gnt is ever high per cycle, and never together with rvalid for the other master.
- rdata of the non-owner, and of both masters outside RDATA, is 0.
- Reset asserted in RDATA:
  - The pending read is dropped and rvalid does not assert.
  - After release, the FSM starts in IDLE with starve_cnt=0.
- mem_we is never nonzero when mem_en=0.

Test Plan:
- Single read: m0_req=1, we=0, addr=0x0000_0010 → cycle 0: m0_gnt=1, mem_en=1, mem_addr=0x4, mem_we=0. Cycle 1: memory returns 0xDEADBEEF, so m0_rvalid=1 and m0_rdata=0xDEADBEEF, m1_rdata=0.
- Write with lanes: m1 writes addr=0x8, wdata=0x11223344, wstrb=4'b0011 with m0 idle → m1_gnt=1, mem_we=4'b0011, mem_addr=0x2 in the same cycle. The next cycle is IDLE and accepts a new request.
- Contention/starvation, STARVE_LIMIT=4: both request writes continuously → m0 is granted 4 times, then m1 once, then m0 4 more times. starve_cnt returns to 0 after the m1 grant.
- Read blocking: m0 read granted at cycle 0 and m1 write pending → m1_gnt=0 at cycle 1 (RDATA) and m1_gnt=1 at cycle 2.
- Reset mid-read: assert reset_n=0 in the RDATA cycle → m0_rvalid=0 immediately, all outputs 0. After release, the first m1 request is granted in IDLE.
- Request withdrawal: m1_req pulses for 1 cycle while m0 is granted → no m1 grant, no m1 access, starve_cnt cleared once m1_req=0.
